muldiv_unit: RTL
================

# muldiv_unit

Multi-cycle multiply/divide execution unit for the RV32M extension, sitting in the execute stage directly downstream of the ALU decoder. It consumes the 4-bit `aluControl` code produced for `aluOp = 2'b11` together with both operands, runs a fixed-latency multiply or an iterative radix-2 divide, and returns a WIDTH-bit result with a start/busy/done handshake so the pipeline can stall on it.

## Interface
- `WIDTH`, 32, operand and result width; the divider iteration count equals WIDTH.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; asserted only when the decoded instruction is M-extension (`aluOp = 2'b11`).
- `aluControl`  in  4  operation code: 1010 MUL, 1011 MULH, 1100 MULHSU, 1001 MULHU, 1110 DIV, 1111 DIVU, 0110 REM, 0111 REMU.
- `srcA`  in  WIDTH  rs1 operand (dividend / multiplicand).
- `srcB`  in  WIDTH  rs2 operand (divisor / multiplier).
- `flush`  in  1  pipeline kill; abandons any operation in flight.
- `busy`  out  1  high whenever the unit is not IDLE.
- `done`  out  1  single-cycle pulse; `result` is valid in this cycle.
- `result`  out  WIDTH  operation result; held until the next accepted start.

## Operation
- States: IDLE, MUL, DIV, DONE. `busy = (state != IDLE)`. `done = (state == DONE)`.
- IDLE: when `start=1` and `flush=0`, latch `aluControl`, `srcA`, `srcB`, and select the next state:
  - Multiply codes → MUL.
  - DIV/DIVU/REM/REMU with a nonzero divisor and no signed overflow → DIV.
  - Divide by zero, signed overflow, or an unmapped code → MUL path (computed in a single cycle).
- `start` is ignored outside IDLE; the upstream logic holds the instruction while `busy` is high.
- MUL: form the 2·WIDTH product, then go to DONE.
  - MUL returns the low WIDTH bits.
  - MULH is signed×signed, MULHSU is signed srcA × unsigned srcB, MULHU is unsigned×unsigned; each returns the high WIDTH bits.
- DIV: restoring radix-2 on operand magnitudes (signed ops take the absolute value), with a counter running WIDTH-1 down to 0 and one quotient bit per cycle. When the counter reaches 0, go to DONE.
  - Sign fix-up is applied when the result is latched.
  - Signed quotient is negative iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Special cases (RISC-V defined):
  - Divisor 0: quotient = all ones; remainder = srcA.
  - DIV/REM with srcA = 0x80000000 and srcB = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Unmapped code: result = 0.
- DONE: `done=1` for exactly one cycle, then IDLE.
- `flush` in any state: next state IDLE, no `done` pulse, `result` unchanged. `flush` has priority over `start`.
- Reset: state IDLE, counter 0, `busy=0`, `done=0`, `result=0`.

## Timing
- `start` sampled high in IDLE at edge k.
- Multiply and special cases: MUL during cycle k+1; `done=1` and `result` valid in cycle k+2. Latency 2.
- Normal divide: DIV during cycles k+1 … k+WIDTH; `done=1` in cycle k+WIDTH+1 (k+33 at WIDTH=32).
- `busy` rises in cycle k+1 and falls in the cycle after `done`.
- Back-to-back: a new start is accepted at the edge ending the cycle after DONE (IDLE), so the minimum issue interval is 3 cycles for multiplies.
- `rst` or `flush` asserted mid-DIV: IDLE on the next edge, and partial quotient/remainder registers are discarded.
- `result` registered output changes only on entry to DONE or on reset.

## Test plan
- MUL 7×(−3): srcA=7, srcB=0xFFFFFFFD → `done` at k+2, result 0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3: srcA=0xFFFFFFEC, srcB=3 → `done` exactly at k+33, result 0xFFFFFFFA. REM on the same operands → 0xFFFFFFFE. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. Both have latency 2.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM on the same operands → 0. Latency 2.
- Flush at cycle k+10 of a DIV → IDLE at k+11, no `done`, `result` keeps its previous value. A subsequent start is accepted normally.
- `rst` mid-MUL → all outputs 0. `start` held during `busy` → exactly one `done` per accepted start.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV32M execute-stage multiply/divide unit: two-cycle multiply and special cases,
// iterative restoring radix-2 divide, start/busy/done handshake with flush.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluControl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam logic [3:0] OP_MUL    = 4'b1010;
    localparam logic [3:0] OP_MULH   = 4'b1011;
    localparam logic [3:0] OP_MULHSU = 4'b1100;
    localparam logic [3:0] OP_MULHU  = 4'b1001;
    localparam logic [3:0] OP_DIV    = 4'b1110;
    localparam logic [3:0] OP_DIVU   = 4'b1111;
    localparam logic [3:0] OP_REM    = 4'b0110;
    localparam logic [3:0] OP_REMU   = 4'b0111;

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [3:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept, sgn_in, div_go;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0] mul_res, div_res, rem_nx, quot_nx;
    logic [WIDTH:0]   rem_sh, diff;
    logic             ge;

    assign accept = (state_q == S_IDLE) && start && !flush;
    assign sgn_in = is_signed_div(aluControl);
    // Zero divisor and INT_MIN/-1 bypass the iterative path and resolve in the MUL state.
    assign div_go = is_div_op(aluControl) && (srcB != '0)
                    && !(sgn_in && (srcA == INT_MIN) && (srcB == ALL_ONES));

    assign a_ext = ((op_q == OP_MULH) || (op_q == OP_MULHSU))
                   ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign b_ext = (op_q == OP_MULH) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = a_ext * b_ext;

    always_comb begin
        mul_res = '0;
        case (op_q)
            OP_MUL:                       mul_res = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: mul_res = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              mul_res = (b_q == '0) ? ALL_ONES : a_q;
            OP_REM, OP_REMU:              mul_res = (b_q == '0) ? a_q : '0;
            default:                      mul_res = '0;
        endcase
    end

    // One restoring step: a_q shifts dividend bits out and quotient bits in.
    assign rem_sh  = {rem_q, a_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign ge      = ~diff[WIDTH];
    assign rem_nx  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quot_nx = {a_q[WIDTH-2:0], ge};
    assign div_res = is_rem_op(op_q) ? negate_if(rem_nx, rneg_q) : negate_if(quot_nx, qneg_q);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = aluControl;
                    qneg_d = sgn_in && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                    rneg_d = sgn_in && srcA[WIDTH-1];
                    rem_d  = '0;
                    if (div_go) begin
                        a_d     = negate_if(srcA, sgn_in && srcA[WIDTH-1]);
                        b_d     = negate_if(srcB, sgn_in && srcB[WIDTH-1]);
                        cnt_d   = CNT_LAST;
                        state_d = S_DIV;
                    end else begin
                        a_d     = srcA;
                        b_d     = srcB;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                result_d = mul_res;
                state_d  = S_DONE;
            end
            S_DIV: begin
                a_d   = quot_nx;
                rem_d = rem_nx;
                if (cnt_q == '0) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        a_q    <= a_d;
        b_q    <= b_d;
        rem_q  <= rem_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
endmodule
